act_skew_feeder: RTL and testbench

//  Streams activation rows from the activation scratchpad into the west edge of the

---
 rtl/act_skew_feeder_pkg.sv | 18 +
 rtl/act_skew_feeder_if.sv | 34 +++
 rtl/act_skew_feeder_skew.sv | 40 ++++
 rtl/act_skew_feeder.sv | 163 ++++++++++++++++
 tb/tb_act_skew_feeder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/act_skew_feeder_pkg.sv
// Shared configuration for the activation skew feeder: array geometry,
// scratchpad geometry, the activation row type and the feeder FSM states.
package act_skew_feeder_pkg;

  localparam int SUPER_SYS_ROWS   = 16;
  localparam int A_BITWIDTH       = 8;
  localparam int SCRATCHPAD_DEPTH = 128;
  localparam int SP_ADDR_W        = $clog2(SCRATCHPAD_DEPTH);

  typedef logic [SUPER_SYS_ROWS-1:0][A_BITWIDTH-1:0] act_row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/act_skew_feeder_if.sv
// Command, scratchpad read port and array-edge signals of the feeder.
// The master modport is the feeder itself; the slave modport is the
// surrounding controller / scratchpad / array side.
interface act_skew_feeder_if
  import act_skew_feeder_pkg::*;
#(
  parameter int SYS_ROWS = SUPER_SYS_ROWS,
  parameter int A_BW     = A_BITWIDTH,
  parameter int ADDR_W   = SP_ADDR_W
);

  logic                     start_i;
  logic [ADDR_W-1:0]        base_addr_i;
  logic [ADDR_W:0]          num_rows_i;
  logic                     stall_i;
  logic                     sp_rd_en_o;
  logic [ADDR_W-1:0]        sp_rd_addr_o;
  logic [SYS_ROWS*A_BW-1:0] sp_rd_data_i;
  logic [SYS_ROWS*A_BW-1:0] act_o;
  logic [SYS_ROWS-1:0]      act_valid_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    input  start_i, base_addr_i, num_rows_i, stall_i, sp_rd_data_i,
    output sp_rd_en_o, sp_rd_addr_o, act_o, act_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_addr_i, num_rows_i, stall_i, sp_rd_data_i,
    input  sp_rd_en_o, sp_rd_addr_o, act_o, act_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/act_skew_feeder_skew.sv
// Enable-gated shift chain carrying one activation lane plus its valid bit.
// Data entering without valid is stored as zero so the chain output is
// already zero-masked for idle slots.
module skew_delay_line #(
  parameter int DEPTH_R = 1,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic [W-1:0] q,
  output logic         q_valid
);

  logic [W-1:0]       data_r [DEPTH_R];
  logic [DEPTH_R-1:0] valid_r;

  // Shift data and valid one stage per enabled cycle; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_R; i++) begin
        data_r[i] <= '0;
      end
      valid_r <= '0;
    end else if (en) begin
      data_r[0]  <= d_valid ? d : '0;
      valid_r[0] <= d_valid;
      for (int i = 1; i < DEPTH_R; i++) begin
        data_r[i]  <= data_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  assign q       = data_r[DEPTH_R-1];
  assign q_valid = valid_r[DEPTH_R-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Streams scratchpad rows into the west edge of the systolic array with a
// diagonal skew (lane r delayed r cycles behind lane 0), then drains the
// chains and pulses done once the last lane has emptied.
module act_skew_feeder
  import act_skew_feeder_pkg::*;
#(
  parameter int SYS_ROWS = SUPER_SYS_ROWS,
  parameter int A_BW     = A_BITWIDTH,
  parameter int DEPTH    = SCRATCHPAD_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  act_skew_feeder_if.master bus
);

  localparam int                DRAIN_W  = $clog2(SYS_ROWS + 2);
  localparam logic [ADDR_W:0]   MAX_ROWS = (ADDR_W+1)'(DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SYS_ROWS);

  feeder_state_t       state_r, state_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic [ADDR_W:0]     count_r, count_s;
  logic [ADDR_W:0]     k_r, k_s;
  logic [DRAIN_W-1:0]  drain_cnt_r, drain_cnt_s;
  logic                done_r, done_s;
  logic                busy_r;
  logic                rd_en_s;
  logic                rd_issued_r;
  logic                shift_en_s;
  logic [ADDR_W:0]     req_rows_s;
  logic [A_BW-1:0]     lane_data_s [SYS_ROWS];
  logic [SYS_ROWS-1:0] lane_valid_s;

  // Requests beyond the scratchpad size read every row exactly once.
  function automatic logic [ADDR_W:0] clamp_rows(input logic [ADDR_W:0] n);
    if (n > MAX_ROWS) begin
      return MAX_ROWS;
    end else begin
      return n;
    end
  endfunction

  assign req_rows_s = clamp_rows(bus.num_rows_i);

  // Next-state, read issue and completion decode for the feeder FSM.
  always_comb begin
    state_s     = state_r;
    base_s      = base_r;
    count_s     = count_r;
    k_s         = k_r;
    drain_cnt_s = drain_cnt_r;
    done_s      = 1'b0;
    rd_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // done_r high means this is the completion cycle: starts are dropped.
        if (bus.start_i && !done_r) begin
          base_s      = bus.base_addr_i;
          count_s     = req_rows_s;
          k_s         = '0;
          drain_cnt_s = '0;
          if (req_rows_s == '0) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (!bus.stall_i) begin
          rd_en_s = 1'b1;
          if ((k_r + (ADDR_W+1)'(1)) == count_r) begin
            k_s         = '0;
            drain_cnt_s = '0;
            state_s     = DRAIN;
          end else begin
            k_s = k_r + (ADDR_W+1)'(1);
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      DRAIN: begin
        // One cycle for the final read data plus one per lane of skew.
        if (!bus.stall_i) begin
          if (drain_cnt_r == DRAIN_LAST) begin
            drain_cnt_s = '0;
            done_s      = 1'b1;
            state_s     = IDLE;
          end else begin
            drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
          end
        end else begin
          drain_cnt_s = drain_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, command latches, counters and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      base_r      <= '0;
      count_r     <= '0;
      k_r         <= '0;
      drain_cnt_r <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      base_r      <= base_s;
      count_r     <= count_s;
      k_r         <= k_s;
      drain_cnt_r <= drain_cnt_s;
      done_r      <= done_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  // Chains advance on every non-stalled cycle; a stall in IDLE is ignored.
  assign shift_en_s = !bus.stall_i || (state_r == IDLE);

  // Marks that sp_rd_data_i holds a fresh row; held across stalls because
  // the scratchpad keeps its output while rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_issued_r <= 1'b0;
    end else if (shift_en_s) begin
      rd_issued_r <= rd_en_s;
    end
  end

  for (genvar r = 0; r < SYS_ROWS; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH_R (r + 1),
      .W       (A_BW)
    ) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (shift_en_s),
      .d       (bus.sp_rd_data_i[r*A_BW +: A_BW]),
      .d_valid (rd_issued_r),
      .q       (lane_data_s[r]),
      .q_valid (lane_valid_s[r])
    );
    assign bus.act_o[r*A_BW +: A_BW] = lane_data_s[r];
  end

  assign bus.act_valid_o  = lane_valid_s;
  assign bus.sp_rd_en_o   = rd_en_s;
  assign bus.sp_rd_addr_o = rd_en_s ? (base_r + k_r[ADDR_W-1:0]) : '0;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: the command driver records the
// expected read addresses, per-lane activations and done cycle; a negedge
// monitor consumes them as the DUT presents outputs.
module tb_act_skew_feeder;
  import act_skew_feeder_pkg::*;

  localparam int NR = SUPER_SYS_ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // expected[key] tables: reads keyed by cycle, lanes by cycle*NR+lane
  int exp_rd [int];
  int exp_lane [int];
  int exp_done [int];
  int busy_lo = 1;
  int busy_hi = 0;

  logic               stall_prev = 1'b0;
  logic [NR*8-1:0]    act_prev = '0;
  logic [NR-1:0]      val_prev = '0;

  act_skew_feeder_if bus ();

  act_skew_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cycle n is the period following the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] elem(input int row, input int lane);
    int v;
    v = row * 16 + lane;
    return v[7:0];
  endfunction

  // scratchpad: 1-cycle latency, output held while rd_en is low
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.sp_rd_data_i <= '0;
    end else if (bus.sp_rd_en_o) begin
      for (int r = 0; r < NR; r++) begin
        bus.sp_rd_data_i[r*8 +: 8] <= elem(int'(bus.sp_rd_addr_o), r);
      end
    end
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: consume expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst_n) begin
      chk(!bus.sp_rd_en_o && !bus.busy_o && !bus.done_o && bus.act_o == '0 && bus.act_valid_o == '0,
          "reset_zero", longint'(bus.act_valid_o), 0);
    end else begin
      bit bad;
      if (bus.sp_rd_en_o) begin
        if (exp_rd.exists(cyc)) begin
          chk(int'(bus.sp_rd_addr_o) == exp_rd[cyc], "rd_addr", bus.sp_rd_addr_o, exp_rd[cyc]);
          exp_rd.delete(cyc);
        end else begin
          chk(1'b0, "rd_unexpected", bus.sp_rd_addr_o, -1);
        end
      end
      if (!stall_prev) begin
        for (int r = 0; r < NR; r++) begin
          if (bus.act_valid_o[r]) begin
            int key;
            key = cyc * NR + r;
            if (exp_lane.exists(key)) begin
              chk(int'(bus.act_o[r*8 +: 8]) == exp_lane[key], "lane_data", bus.act_o[r*8 +: 8], exp_lane[key]);
              exp_lane.delete(key);
            end else begin
              chk(1'b0, "lane_unexpected", r, -1);
            end
          end
        end
      end else begin
        chk(bus.act_o == act_prev && bus.act_valid_o == val_prev, "frozen",
            longint'(bus.act_valid_o), longint'(val_prev));
      end
      bad = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if (!bus.act_valid_o[r] && bus.act_o[r*8 +: 8] != 8'h00) bad = 1'b1;
      end
      chk(!bad, "zero_lane", longint'(bad), 0);
      if (bus.done_o) begin
        if (exp_done.exists(cyc)) begin
          chk(!bus.busy_o, "done_busy", bus.busy_o, 0);
          exp_done.delete(cyc);
        end else begin
          chk(1'b0, "done_unexpected", cyc, -1);
        end
      end
      chk(bus.busy_o == (cyc >= busy_lo && cyc <= busy_hi), "busy", bus.busy_o,
          (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
    stall_prev = bus.stall_i;
    act_prev   = bus.act_o;
    val_prev   = bus.act_valid_o;
  end

  // Issue one command and record its expected trace.
  // stall window: relative cycles [s, s+n); rst_at>0 pulls reset at that relative cycle.
  task automatic run_cmd(input int base, input int num, input int s, input int n,
                         input bit dup, input bit start_on_done, input int rst_at);
    int t0, cnt, t, d;
    t0  = cyc;
    cnt = (num > 128) ? 128 : num;
    for (int i = 0; i < cnt; i++) begin
      t = 1 + i;
      if (n > 0 && t >= s) t += n;
      exp_rd[t0 + t] = (base + i) % 128;
      for (int r = 0; r < NR; r++) begin
        t = 3 + r + i;
        if (n > 0 && t > s) t += n;
        exp_lane[(t0 + t) * NR + r] = int'(elem((base + i) % 128, r));
      end
    end
    d = (cnt == 0) ? 1 : cnt + 18;
    if (cnt > 0 && n > 0 && d > s) d += n;
    exp_done[t0 + d] = 1;
    if (cnt > 0) begin
      busy_lo = t0 + 1;
      busy_hi = t0 + d - 1;
    end
    for (int c = 0; c <= d + 2; c++) begin
      bus.start_i = (c == 0) || (dup && c == 5) || (start_on_done && c == d);
      if (c == 0) begin
        bus.base_addr_i = 7'(base);
        bus.num_rows_i  = 8'(num);
      end else begin
        bus.base_addr_i = 7'd50;
        bus.num_rows_i  = 8'd2;
      end
      bus.stall_i = (n > 0 && c >= s && c < s + n);
      if (rst_at > 0 && c == rst_at) begin
        bus.start_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk(!bus.sp_rd_en_o && !bus.busy_o && !bus.done_o && bus.act_o == '0 && bus.act_valid_o == '0,
            "reset_immediate", longint'(bus.act_valid_o), 0);
        exp_rd.delete();
        exp_lane.delete();
        exp_done.delete();
        busy_lo = 1;
        busy_hi = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      step();
    end
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    chk(exp_rd.size() == 0, "rd_missing", exp_rd.size(), 0);
    chk(exp_lane.size() == 0, "lane_missing", exp_lane.size(), 0);
    chk(exp_done.size() == 0, "done_missing", exp_done.size(), 0);
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.num_rows_i  = '0;
    bus.stall_i     = 1'b0;
    // 1: reset held while start toggles
    for (int i = 0; i < 4; i++) begin
      step();
      bus.start_i = ~bus.start_i;
      bus.num_rows_i = 8'd3;
    end
    bus.start_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    // 2: basic streaming
    run_cmd(0, 3, 0, 0, 1'b0, 1'b0, 0);
    // 3: address wrap 126,127,0,1
    run_cmd(126, 4, 0, 0, 1'b0, 1'b0, 0);
    // 4: two stall cycles after the second read
    run_cmd(0, 3, 3, 2, 1'b0, 1'b0, 0);
    // 5: zero-length command, start while busy, start on the done cycle
    run_cmd(0, 0, 0, 0, 1'b0, 1'b0, 0);
    run_cmd(0, 3, 0, 0, 1'b1, 1'b0, 0);
    run_cmd(0, 3, 0, 0, 1'b0, 1'b1, 0);
    // 6: reset in DRAIN, then a fresh command reproduces the basic trace
    run_cmd(0, 3, 0, 0, 1'b0, 1'b0, 10);
    run_cmd(0, 3, 0, 0, 1'b0, 1'b0, 0);
    // oversize count clamps to the full scratchpad starting at base
    run_cmd(5, 200, 0, 0, 1'b0, 1'b0, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
